// File: rtl/irq_sync.sv
// irq_sync: interrupt front-end for the MIPS pipeline CPU.
// Each of the 30 device lines is polarity-normalized, synchronized into the
// clk domain, glitch-filtered and turned into a one-cycle (edge) or held
// (level) request bit in ir_map, which CP0 ORs into its Cause register.

module irq_sync #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4,
    parameter logic [29:0] EDGE_MASK     = 30'h3FFFFFFF,
    parameter logic [29:0] POLARITY      = 30'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [30:1] irq_in,
    input  logic        en,
    output logic [30:1] ir_map,
    output logic [30:1] irq_state
);

    // Terminal count of the filter: a line must disagree with its filtered
    // state for FILTER_CYCLES consecutive cycles before the state flips.
    localparam logic [7:0] FILT_MAX = 8'(FILTER_CYCLES - 1);

    logic [30:1] raw;
    logic [30:1] sync_q [SYNC_STAGES];
    logic [30:1] sync_out;
    logic [7:0]  cnt_q [1:30];
    logic [30:1] state_q;
    logic [30:1] state_d;
    logic [30:1] edge_sel;

    assign raw       = irq_in ^ POLARITY;
    assign sync_out  = sync_q[SYNC_STAGES-1];
    assign edge_sel  = EDGE_MASK;
    assign irq_state = state_q;

    // Synchronizer chain: first stage samples the asynchronous lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= raw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Per-line glitch filter: count consecutive disagreeing cycles, flip on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            for (int i = 1; i <= 30; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 1; i <= 30; i++) begin
                if (sync_out[i] == state_q[i]) begin
                    cnt_q[i] <= 8'd0;
                end else if (cnt_q[i] == FILT_MAX) begin
                    state_q[i] <= ~state_q[i];
                    cnt_q[i]   <= 8'd0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // Request generator: edge lines pulse on a rising state, level lines follow state; en gates both.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_d <= '0;
            ir_map  <= '0;
        end else begin
            state_d <= state_q;
            ir_map  <= {30{en}} & state_q & (~state_d | ~edge_sel);
        end
    end

endmodule

// File: tb/tb_irq_sync.sv
// tb_irq_sync: directed bench for irq_sync. Line 12 is configured level,
// active-low; all other lines are edge-triggered, active-high. Each step
// queues the expected ir_map/irq_state for absolute cycle numbers, and the
// queue is drained and compared on every falling edge.

module tb_irq_sync;

    localparam logic [29:0] TB_EDGE_MASK = 30'h3FFFF7FF;
    localparam logic [29:0] TB_POLARITY  = 30'h00000800;

    localparam logic [30:1] L1   = 30'h00000001;
    localparam logic [30:1] L3   = 30'h00000004;
    localparam logic [30:1] L5   = 30'h00000010;
    localparam logic [30:1] L12  = 30'h00000800;
    localparam logic [30:1] L15  = 30'h00004000;
    localparam logic [30:1] L30  = 30'h20000000;
    localparam logic [30:1] IDLE = L12;
    localparam logic [30:1] ZERO = 30'h00000000;

    typedef struct {
        int          at;
        string       tag;
        logic [30:1] map;
        logic [30:1] st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [30:1] irq_in;
    logic [30:1] ir_map;
    logic [30:1] irq_state;

    int   cyc = 0;
    int   base = 0;
    int   assert_count = 0;
    int   fail_count = 0;
    exp_t exp_q[$];

    irq_sync #(
        .SYNC_STAGES  (2),
        .FILTER_CYCLES(4),
        .EDGE_MASK    (TB_EDGE_MASK),
        .POLARITY     (TB_POLARITY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .en       (en),
        .ir_map   (ir_map),
        .irq_state(irq_state)
    );

    // Free-running clock and posedge counter used to time-stamp expectations.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Queue an expectation, kept sorted by cycle.
    task automatic pushExpect(input int at, input string tag,
                              input logic [30:1] m, input logic [30:1] s);
        exp_t e;
        int   idx;
        e.at  = at;
        e.tag = tag;
        e.map = m;
        e.st  = s;
        idx = exp_q.size();
        while (idx > 0 && exp_q[idx-1].at > at) idx--;
        exp_q.insert(idx, e);
    endtask

    // Expectation k cycles after the last applied stimulus.
    task automatic checkOutput(input int k, input string tag,
                               input logic [30:1] m, input logic [30:1] s);
        pushExpect(base + k, tag, m, s);
    endtask

    task automatic checkRange(input int k0, input int k1, input string tag,
                              input logic [30:1] m, input logic [30:1] s);
        for (int k = k0; k <= k1; k++) pushExpect(base + k, tag, m, s);
    endtask

    // Compare every expectation that is due at the current cycle.
    task automatic drainQueue();
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            e = exp_q.pop_front();
            assert_count++;
            assert (ir_map === e.map) else begin
                fail_count++;
                $error("[TB] FAIL %s ir_map cycle %0d observed=%h expected=%h",
                       e.tag, cyc, ir_map, e.map);
            end
            assert_count++;
            assert (irq_state === e.st) else begin
                fail_count++;
                $error("[TB] FAIL %s irq_state cycle %0d observed=%h expected=%h",
                       e.tag, cyc, irq_state, e.st);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        drainQueue();
    endtask

    task automatic waitCycles(input int n);
        repeat (n) tick();
    endtask

    // Drive inputs on a falling edge; the next rising edge is edge 1.
    task automatic applyStimulus(input logic [30:1] lines, input logic en_v,
                                 input logic rst_v);
        tick();
        irq_in = lines;
        en     = en_v;
        rst    = rst_v;
        base   = cyc;
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b1;
        irq_in = IDLE;

        $display("[TB] reset and idle");
        applyStimulus(IDLE, 1'b1, 1'b1);
        checkOutput(1, "reset_hold", ZERO, ZERO);
        applyStimulus(IDLE, 1'b1, 1'b0);
        checkRange(1, 50, "idle", ZERO, ZERO);
        waitCycles(50);

        $display("[TB] edge line 5");
        applyStimulus(IDLE | L5, 1'b1, 1'b0);
        checkOutput(5, "e5_pre", ZERO, ZERO);
        checkOutput(6, "e5_state", ZERO, L5);
        checkOutput(7, "e5_pulse", L5, L5);
        checkRange(8, 15, "e5_hold", ZERO, L5);
        waitCycles(15);
        applyStimulus(IDLE, 1'b1, 1'b0);
        checkOutput(5, "e5_fall_pre", ZERO, L5);
        checkRange(6, 12, "e5_fall", ZERO, ZERO);
        waitCycles(12);

        $display("[TB] glitch on line 3");
        applyStimulus(IDLE | L3, 1'b1, 1'b0);
        checkRange(1, 16, "glitch3", ZERO, ZERO);
        waitCycles(2);
        applyStimulus(IDLE, 1'b1, 1'b0);
        waitCycles(13);

        applyStimulus(IDLE | L3, 1'b1, 1'b0);
        checkRange(1, 5, "clean3_pre", ZERO, ZERO);
        checkOutput(6, "clean3_state", ZERO, L3);
        checkOutput(7, "clean3_pulse", L3, L3);
        checkRange(8, 9, "clean3_after", ZERO, L3);
        checkRange(10, 16, "clean3_fall", ZERO, ZERO);
        waitCycles(3);
        applyStimulus(IDLE, 1'b1, 1'b0);
        waitCycles(12);

        $display("[TB] level line 12 active-low");
        applyStimulus(ZERO, 1'b1, 1'b0);
        checkOutput(5, "l12_pre", ZERO, ZERO);
        checkOutput(6, "l12_state", ZERO, L12);
        checkRange(7, 20, "l12_active", L12, L12);
        waitCycles(20);
        applyStimulus(IDLE, 1'b1, 1'b0);
        checkOutput(5, "l12_rel_pre", L12, L12);
        checkOutput(6, "l12_rel_state", L12, ZERO);
        checkRange(7, 10, "l12_released", ZERO, ZERO);
        waitCycles(10);

        $display("[TB] en gating of edge line 1");
        applyStimulus(IDLE | L1, 1'b1, 1'b0);
        checkOutput(5, "l1_pre", ZERO, ZERO);
        checkRange(6, 14, "l1_gated", ZERO, L1);
        waitCycles(3);
        applyStimulus(IDLE | L1, 1'b0, 1'b0);
        waitCycles(4);
        applyStimulus(IDLE | L1, 1'b1, 1'b0);
        waitCycles(5);
        applyStimulus(IDLE, 1'b1, 1'b0);
        checkOutput(5, "l1_rel_pre", ZERO, L1);
        checkRange(6, 8, "l1_rel", ZERO, ZERO);
        waitCycles(8);

        $display("[TB] en gating of level line 12");
        applyStimulus(ZERO, 1'b0, 1'b0);
        checkRange(6, 10, "l12_en_off", ZERO, L12);
        checkRange(11, 15, "l12_en_back", L12, L12);
        checkOutput(16, "l12_en_drop", ZERO, L12);
        waitCycles(9);
        applyStimulus(ZERO, 1'b1, 1'b0);
        waitCycles(4);
        applyStimulus(ZERO, 1'b0, 1'b0);
        waitCycles(1);
        applyStimulus(IDLE, 1'b1, 1'b0);
        checkRange(1, 5, "l12_reen", L12, L12);
        checkOutput(6, "l12_reen_state", L12, ZERO);
        checkRange(7, 9, "l12_reen_rel", ZERO, ZERO);
        waitCycles(9);

        $display("[TB] simultaneous lines 1, 15, 30");
        applyStimulus(IDLE | L1 | L15 | L30, 1'b1, 1'b0);
        checkOutput(6, "sim_state", ZERO, L1 | L15 | L30);
        checkOutput(7, "sim_pulse", 30'h20004001, L1 | L15 | L30);
        checkRange(8, 10, "sim_after", ZERO, L1 | L15 | L30);
        waitCycles(10);
        applyStimulus(IDLE, 1'b1, 1'b0);
        checkRange(6, 8, "sim_rel", ZERO, ZERO);
        waitCycles(8);

        $display("[TB] reset mid-filter");
        applyStimulus(IDLE | L5, 1'b1, 1'b0);
        checkRange(5, 20, "rst_midfilter", ZERO, ZERO);
        waitCycles(3);
        applyStimulus(IDLE, 1'b1, 1'b1);
        applyStimulus(IDLE, 1'b1, 1'b0);
        waitCycles(15);

        $display("[TB] line active across reset release");
        applyStimulus(IDLE | L5, 1'b1, 1'b1);
        applyStimulus(IDLE | L5, 1'b1, 1'b1);
        applyStimulus(IDLE | L5, 1'b1, 1'b0);
        checkOutput(5, "fresh_pre", ZERO, ZERO);
        checkOutput(6, "fresh_state", ZERO, L5);
        checkOutput(7, "fresh_pulse", L5, L5);
        checkRange(8, 10, "fresh_after", ZERO, L5);
        waitCycles(10);

        for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick();
        assert_count++;
        assert (exp_q.size() == 0) else begin
            fail_count++;
            $error("[TB] FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
